// File: rtl/dca_matrix_lsu_pkg.sv
// Shared types, constants and instruction decode helpers for the DCA matrix LSU responder.
// Instruction layout (LSB first): opcode, num_col_m1, num_row_m1, stride, base address.
package dca_matrix_lsu_pkg;

   localparam int MATRIX_SIZE_PARA = 8;
   localparam int BW_ELEMENT       = 32;
   localparam int BW_ADDR          = 32;
   localparam int BW_ROW           = MATRIX_SIZE_PARA * BW_ELEMENT;
   localparam int BW_DIM           = $clog2(MATRIX_SIZE_PARA);
   localparam int BW_OPCODE        = 2;
   localparam int BW_BLOCK_INFO    = 2 * BW_ADDR + 2 * BW_DIM;
   localparam int BW_DCA_MATRIX_LSU_INST = BW_BLOCK_INFO + BW_OPCODE;

   localparam logic [BW_OPCODE-1:0] OPC_READ  = 2'd1;
   localparam logic [BW_OPCODE-1:0] OPC_WRITE = 2'd2;

   localparam int OFS_OPCODE  = 0;
   localparam int OFS_NUM_COL = OFS_OPCODE + BW_OPCODE;
   localparam int OFS_NUM_ROW = OFS_NUM_COL + BW_DIM;
   localparam int OFS_STRIDE  = OFS_NUM_ROW + BW_DIM;
   localparam int OFS_ADDR    = OFS_STRIDE + BW_ADDR;

   typedef logic [BW_DCA_MATRIX_LSU_INST-1:0] lsu_inst_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_REQ,
      ST_RD_OUT,
      ST_RD_PAD,
      ST_WR_IN,
      ST_WR_REQ,
      ST_DONE
   } lsu_state_e;

   function automatic logic [BW_OPCODE-1:0] inst_opcode(input lsu_inst_t inst);
      return inst[OFS_OPCODE +: BW_OPCODE];
   endfunction

   function automatic logic [BW_DIM-1:0] inst_num_col_m1(input lsu_inst_t inst);
      return inst[OFS_NUM_COL +: BW_DIM];
   endfunction

   function automatic logic [BW_DIM-1:0] inst_num_row_m1(input lsu_inst_t inst);
      return inst[OFS_NUM_ROW +: BW_DIM];
   endfunction

   function automatic logic [BW_ADDR-1:0] inst_stride(input lsu_inst_t inst);
      return inst[OFS_STRIDE +: BW_ADDR];
   endfunction

   function automatic logic [BW_ADDR-1:0] inst_addr(input lsu_inst_t inst);
      return inst[OFS_ADDR +: BW_ADDR];
   endfunction

   function automatic lsu_inst_t pack_inst(input logic [BW_OPCODE-1:0] opcode,
                                           input logic [BW_ADDR-1:0]   addr,
                                           input logic [BW_ADDR-1:0]   stride,
                                           input logic [BW_DIM-1:0]    num_row_m1,
                                           input logic [BW_DIM-1:0]    num_col_m1);
      return {addr, stride, num_row_m1, num_col_m1, opcode};
   endfunction

   // All-ones over lanes 0..num_col_m1, zero over the unused columns.
   function automatic logic [BW_ROW-1:0] col_mask(input logic [BW_DIM-1:0] num_col_m1);
      logic [BW_ROW-1:0] m;
      m = '0;
      for (int l = 0; l < MATRIX_SIZE_PARA; l++) begin
         if (l <= int'(num_col_m1)) m[l*BW_ELEMENT +: BW_ELEMENT] = '1;
      end
      return m;
   endfunction

endpackage

// File: rtl/dca_matrix_lsu_responder_if.sv
// Instruction, memory and load/store stream signals of one LSU responder.
// slave = responder side, master = sequencer/memory/stream side.
interface dca_matrix_lsu_responder_if;
   import dca_matrix_lsu_pkg::*;

   logic                              inst_valid;
   logic                              inst_ready;
   logic [BW_DCA_MATRIX_LSU_INST-1:0] inst;
   logic                              inst_done;

   logic                              mreq;
   logic                              mwrite;
   logic [BW_ADDR-1:0]                maddr;
   logic [BW_ROW-1:0]                 mwdata;
   logic                              mack;
   logic [BW_ROW-1:0]                 mrdata;

   logic                              load_valid;
   logic                              load_ready;
   logic [BW_ROW-1:0]                 load_data;

   logic                              store_valid;
   logic                              store_ready;
   logic [BW_ROW-1:0]                 store_data;

   modport slave (
      input  inst_valid, inst, mack, mrdata, load_ready, store_valid, store_data,
      output inst_ready, inst_done, mreq, mwrite, maddr, mwdata, load_valid, load_data, store_ready
   );

   modport master (
      output inst_valid, inst, mack, mrdata, load_ready, store_valid, store_data,
      input  inst_ready, inst_done, mreq, mwrite, maddr, mwdata, load_valid, load_data, store_ready
   );

endinterface

// File: rtl/dca_matrix_lsu_addr_gen.sv
// Row address generator: address accumulator (base + r*stride, wrapping) and row counter.
module dca_matrix_lsu_addr_gen
   import dca_matrix_lsu_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               init_i,
   input  logic               advance_i,
   input  logic [BW_ADDR-1:0] base_i,
   input  logic [BW_ADDR-1:0] stride_i,
   input  logic [BW_DIM-1:0]  num_row_m1_i,
   output logic [BW_ADDR-1:0] maddr_o,
   output logic               is_last_row_o
);

   logic [BW_ADDR-1:0] addr_q, addr_d;
   logic [BW_ADDR-1:0] stride_q, stride_d;
   logic [BW_DIM-1:0]  row_q, row_d;
   logic [BW_DIM-1:0]  num_row_m1_q, num_row_m1_d;

   always_comb begin
      addr_d       = addr_q;
      stride_d     = stride_q;
      row_d        = row_q;
      num_row_m1_d = num_row_m1_q;
      if (init_i) begin
         addr_d       = base_i;
         stride_d     = stride_i;
         row_d        = '0;
         num_row_m1_d = num_row_m1_i;
      end else if (advance_i) begin
         // Plain modular add: the address silently wraps at 2^BW_ADDR.
         addr_d = addr_q + stride_q;
         row_d  = row_q + BW_DIM'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q       <= '0;
         stride_q     <= '0;
         row_q        <= '0;
         num_row_m1_q <= '0;
      end else begin
         addr_q       <= addr_d;
         stride_q     <= stride_d;
         row_q        <= row_d;
         num_row_m1_q <= num_row_m1_d;
      end
   end

   assign maddr_o       = addr_q;
   assign is_last_row_o = (row_q == num_row_m1_q);

endmodule

// File: rtl/dca_matrix_lsu_responder.sv
// Matrix LSU responder: runs one READ/WRITE block instruction at a time over a single memory port.
// Optional DCA_MATRIX_LSU_ZERO_PAD_EN: READ masks unused columns and pads to MATRIX_SIZE_PARA rows.
module dca_matrix_lsu_responder
   import dca_matrix_lsu_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   dca_matrix_lsu_responder_if.slave lsu_if
);

   lsu_state_e        state_q;
   logic              inst_ready_q;
   logic              inst_done_q;
   logic              mreq_q;
   logic              mwrite_q;
   logic              load_valid_q;
   logic              store_ready_q;
   logic [BW_ROW-1:0] mwdata_q;
   logic [BW_ROW-1:0] load_data_q;

`ifdef DCA_MATRIX_LSU_ZERO_PAD_EN
   logic [BW_DIM-1:0] num_col_m1_q;
   logic [BW_DIM-1:0] num_row_m1_q;
   logic [BW_DIM-1:0] pad_left_q;
`endif

   logic               ag_init;
   logic               ag_advance;
   logic               is_last_row;
   logic [BW_ADDR-1:0] maddr;

   // The address generator steps on the same edge the FSM leaves a row, so the
   // new address is already on maddr when mreq rises again.
   assign ag_init    = (state_q == ST_IDLE) && lsu_if.inst_valid;
   assign ag_advance = ((state_q == ST_RD_OUT) && lsu_if.load_ready && !is_last_row) ||
                       ((state_q == ST_WR_REQ) && lsu_if.mack && !is_last_row);

   dca_matrix_lsu_addr_gen u_addr_gen (
      .clk          (clk),
      .rst          (rst),
      .init_i       (ag_init),
      .advance_i    (ag_advance),
      .base_i       (inst_addr(lsu_if.inst)),
      .stride_i     (inst_stride(lsu_if.inst)),
      .num_row_m1_i (inst_num_row_m1(lsu_if.inst)),
      .maddr_o      (maddr),
      .is_last_row_o(is_last_row)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         inst_ready_q  <= 1'b1;
         inst_done_q   <= 1'b0;
         mreq_q        <= 1'b0;
         mwrite_q      <= 1'b0;
         load_valid_q  <= 1'b0;
         store_ready_q <= 1'b0;
         mwdata_q      <= '0;
         load_data_q   <= '0;
`ifdef DCA_MATRIX_LSU_ZERO_PAD_EN
         num_col_m1_q  <= '0;
         num_row_m1_q  <= '0;
         pad_left_q    <= '0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (lsu_if.inst_valid) begin
                  inst_ready_q <= 1'b0;
`ifdef DCA_MATRIX_LSU_ZERO_PAD_EN
                  num_col_m1_q <= inst_num_col_m1(lsu_if.inst);
                  num_row_m1_q <= inst_num_row_m1(lsu_if.inst);
`endif
                  case (inst_opcode(lsu_if.inst))
                     OPC_READ: begin
                        state_q  <= ST_RD_REQ;
                        mreq_q   <= 1'b1;
                        mwrite_q <= 1'b0;
                     end
                     OPC_WRITE: begin
                        state_q       <= ST_WR_IN;
                        store_ready_q <= 1'b1;
                     end
                     default: begin
                        // Unknown opcode retires its credit without touching memory.
                        state_q     <= ST_DONE;
                        inst_done_q <= 1'b1;
                     end
                  endcase
               end
            end

            ST_RD_REQ: begin
               if (lsu_if.mack) begin
                  mreq_q       <= 1'b0;
                  load_valid_q <= 1'b1;
`ifdef DCA_MATRIX_LSU_ZERO_PAD_EN
                  load_data_q  <= lsu_if.mrdata & col_mask(num_col_m1_q);
`else
                  load_data_q  <= lsu_if.mrdata;
`endif
                  state_q      <= ST_RD_OUT;
               end
            end

            ST_RD_OUT: begin
               if (lsu_if.load_ready) begin
                  if (!is_last_row) begin
                     load_valid_q <= 1'b0;
                     mreq_q       <= 1'b1;
                     state_q      <= ST_RD_REQ;
                  end else begin
`ifdef DCA_MATRIX_LSU_ZERO_PAD_EN
                     if (num_row_m1_q != BW_DIM'(MATRIX_SIZE_PARA - 1)) begin
                        // load_valid stays high; the zero rows need no memory beat.
                        load_data_q <= '0;
                        pad_left_q  <= BW_DIM'(MATRIX_SIZE_PARA - 2) - num_row_m1_q;
                        state_q     <= ST_RD_PAD;
                     end else begin
                        load_valid_q <= 1'b0;
                        inst_done_q  <= 1'b1;
                        state_q      <= ST_DONE;
                     end
`else
                     load_valid_q <= 1'b0;
                     inst_done_q  <= 1'b1;
                     state_q      <= ST_DONE;
`endif
                  end
               end
            end

`ifdef DCA_MATRIX_LSU_ZERO_PAD_EN
            ST_RD_PAD: begin
               if (lsu_if.load_ready) begin
                  if (pad_left_q == '0) begin
                     load_valid_q <= 1'b0;
                     inst_done_q  <= 1'b1;
                     state_q      <= ST_DONE;
                  end else begin
                     pad_left_q <= pad_left_q - BW_DIM'(1);
                  end
               end
            end
`endif

            ST_WR_IN: begin
               if (lsu_if.store_valid) begin
                  store_ready_q <= 1'b0;
                  mwdata_q      <= lsu_if.store_data;
                  mreq_q        <= 1'b1;
                  mwrite_q      <= 1'b1;
                  state_q       <= ST_WR_REQ;
               end
            end

            ST_WR_REQ: begin
               if (lsu_if.mack) begin
                  mreq_q   <= 1'b0;
                  mwrite_q <= 1'b0;
                  if (is_last_row) begin
                     inst_done_q <= 1'b1;
                     state_q     <= ST_DONE;
                  end else begin
                     store_ready_q <= 1'b1;
                     state_q       <= ST_WR_IN;
                  end
               end
            end

            ST_DONE: begin
               inst_done_q  <= 1'b0;
               inst_ready_q <= 1'b1;
               state_q      <= ST_IDLE;
            end

            default: begin
               state_q       <= ST_IDLE;
               inst_ready_q  <= 1'b1;
               inst_done_q   <= 1'b0;
               mreq_q        <= 1'b0;
               mwrite_q      <= 1'b0;
               load_valid_q  <= 1'b0;
               store_ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign lsu_if.inst_ready  = inst_ready_q;
   assign lsu_if.inst_done   = inst_done_q;
   assign lsu_if.mreq        = mreq_q;
   assign lsu_if.mwrite      = mwrite_q;
   assign lsu_if.maddr       = maddr;
   assign lsu_if.mwdata      = mwdata_q;
   assign lsu_if.load_valid  = load_valid_q;
   assign lsu_if.load_data   = load_data_q;
   assign lsu_if.store_ready = store_ready_q;

endmodule
